// File: rtl/present_pkg.sv
// Shared PRESENT constants, types and the 4-bit S-box used by both the key
// schedule and the substitution layer.
package present_pkg;

  localparam int ROUND_KEY_W = 64;
  localparam int NUM_KEYS    = 32;

  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sched_state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return PRESENT_SBOX[x];
  endfunction

endpackage

// File: rtl/present_key_update.sv
// One step of the PRESENT key register update: rotate left 61, S-box the top
// nibble(s), XOR the round counter into the fixed counter field.
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic [KEY_SIZE-1:0] key,
  input  logic [4:0]          round_idx,
  output logic [KEY_SIZE-1:0] next_key
);

  logic [KEY_SIZE-1:0] rotated;

  assign rotated = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};

  generate
    if (KEY_SIZE == 80) begin : g_k80
      always_comb begin
        next_key         = rotated;
        next_key[79:76]  = sbox4(rotated[79:76]);
        next_key[19:15]  = rotated[19:15] ^ round_idx;
      end
    end else if (KEY_SIZE == 128) begin : g_k128
      always_comb begin
        next_key          = rotated;
        next_key[127:124] = sbox4(rotated[127:124]);
        next_key[123:120] = sbox4(rotated[123:120]);
        next_key[66:62]   = rotated[66:62] ^ round_idx;
      end
    end else begin : g_bad_size
      $error("present_key_update: KEY_SIZE must be 80 or 128");
    end
  endgenerate

endmodule

// File: rtl/present_key_sched.sv
// Sequential PRESENT key schedule: loads the user key and hands out round keys
// K1..K32 one per Advance request to the round-iteration encrypt datapath.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80,
  parameter int NUM_KEYS = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Load,
  input  logic [KEY_SIZE-1:0] orig_key,
  input  logic                Advance,
  output logic [63:0]         RoundKey,
  output logic [4:0]          Round,
  output logic                KeyValid,
  output logic                Busy,
  output logic                Done,
  output sched_state_t        State
);

  // Handshake: RoundKey/Round are meaningful while KeyValid=1; the consumer
  // pulses Advance once it has used the key, and the next key is presented
  // from the following edge. Load restarts at any time and beats Advance.

  generate
    if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : g_bad_size
      $error("present_key_sched: KEY_SIZE must be 80 or 128");
    end
  endgenerate

  localparam logic [5:0] LAST_I = 6'(NUM_KEYS);

  sched_state_t        state_q, state_next;
  logic [5:0]          i_q, i_next;
  logic [KEY_SIZE-1:0] key_q, key_next, key_upd;
  logic                done_q, done_next;

  present_key_update #(.KEY_SIZE(KEY_SIZE)) u_update (
    .key       (key_q),
    .round_idx (i_q[4:0]),
    .next_key  (key_upd)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      i_q     <= i_next;
      key_q   <= key_next;
      done_q  <= done_next;
    end
  end

  always_comb begin
    state_next = state_q;
    i_next     = i_q;
    key_next   = key_q;
    done_next  = 1'b0;
    if (Load) begin
      state_next = ACTIVE;
      i_next     = 6'd1;
      key_next   = orig_key;
    end else if (state_q == ACTIVE && Advance) begin
      if (i_q == LAST_I) begin
        // Clearing the key here keeps RoundKey at zero throughout IDLE.
        state_next = IDLE;
        i_next     = '0;
        key_next   = '0;
        done_next  = 1'b1;
      end else begin
        key_next = key_upd;
        i_next   = i_q + 6'd1;
      end
    end
  end

  assign RoundKey = key_q[KEY_SIZE-1 -: 64];
  assign Round    = i_q[4:0];
  assign KeyValid = (state_q == ACTIVE);
  assign Busy     = (state_q == ACTIVE);
  assign Done     = done_q;
  assign State    = state_q;

endmodule

// File: doc/present_key_sched.md
# present_key_sched

Sequential PRESENT key schedule that sits directly upstream of the round-iteration encrypt datapath. It loads the user key and delivers the 32 round keys K1..K32 one per consumer request, instead of precomputing a full key array combinationally. The encrypt stage pulls the next round key with `Advance` as each round completes.

## Interface
- `KEY_SIZE`, 80: user key width. Only 80 or 128 are legal; any other value is an elaboration error.
- `NUM_KEYS`, 32: number of round keys delivered (31 rounds plus final whitening).
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load`  in  1  one-cycle start; samples `orig_key`.
- `orig_key`  in  KEY_SIZE  user key; sampled only in the cycle `Load`=1.
- `Advance`  in  1  consumer has used the current round key.
- `RoundKey`  out  64  current round key Ki.
- `Round`  out  5  index of the current key, 1..31; wraps to 0 for K32.
- `KeyValid`  out  1  `RoundKey`/`Round` are meaningful.
- `Busy`  out  1  schedule is in progress (state ACTIVE).
- `Done`  out  1  one-cycle pulse after K32 is consumed.

## Operation
- States are IDLE and ACTIVE. Reset and power-up go to IDLE.
- **IDLE → ACTIVE on `Load`:**
  - key register ← `orig_key`.
  - counter i ← 1.
- **In ACTIVE:**
  - `RoundKey` = key register[KEY_SIZE-1 : KEY_SIZE-64].
  - `KeyValid`=1.
  - `Round` = i[4:0].
- **`Advance` while ACTIVE and i<32:**
  - key register ← update(key register, i).
  - i ← i+1.
- **`Advance` while ACTIVE and i=32:**
  - go to IDLE.
  - `Done`=1 for the following cycle.
  - key register is cleared to 0.
- **update, 80-bit:**
  - rotate left 61.
  - [79:76] ← S([79:76]).
  - [19:15] ^= i[4:0].
- **update, 128-bit:**
  - rotate left 61.
  - [127:124] ← S([127:124]).
  - [123:120] ← S([123:120]).
  - [66:62] ^= i[4:0].
- S is the PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Counter i is 6 bits internally, holding 1..32. Only i[4:0] is XORed and output.
- **Boundary cases:**
  - `Advance` in IDLE: ignored.
  - `Load` in ACTIVE: restarts from the new key at i=1. `Load` has priority over `Advance` in the same cycle.
  - `Load` and `Reset` in the same cycle: `Reset` wins.
  - `Reset` mid-schedule: abandons the schedule and returns to IDLE.
  - `Load` in the same cycle `Done` is asserted: accepted normally.

## Timing
- Reset values:
  - `RoundKey`=0, `Round`=0.
  - `KeyValid`=0, `Busy`=0, `Done`=0.
  - state IDLE, i=0.
- `Load` at edge n → K1 valid from edge n+1. Latency is 1 cycle.
- `Advance` sampled at edge m → K(i+1) valid from edge m+1. One key per cycle at full rate.
- While `Advance`=0 the outputs hold.
- Full schedule with `Advance` held high: K1..K32 appear on 32 consecutive cycles, and `Done` is high on the 33rd cycle after `Load`.
- All outputs are registered. There is no combinational path from any input to any output.
- `Done` and `KeyValid` are never high in the same cycle.
- IDLE outputs: `RoundKey`=0, `Round`=0, `KeyValid`=0.

## Structure
- **Shared package `present_pkg`:**
  - `PRESENT_SBOX` constant array.
  - `ROUND_KEY_W`=64.
  - `NUM_KEYS`=32.
  - sched_state_t enum {IDLE, ACTIVE}.
  - `sbox4` function, shared with the substitution layer.
- **Sub-module `present_key_update`:** combinational, parameterised by `KEY_SIZE`. Inputs are the key and i; output is the next key. It is reused by any later decrypt key schedule.
- The top level holds the FSM, counter and key register only.

## Test plan
- **80-bit zero key:** `Reset`, then `Load` with key=0 and `Advance` held at 1. Required sequence:
  - K1 = 0000000000000000.
  - K2 = C000000000000000.
  - K3 = 5000180000000001.
  - `Round` reads 1, 2, 3.
  - `Done` pulses on cycle 33.
- **Stall:** key=FFFFFFFFFFFFFFFFFFFF, `Advance` toggled 1,0,0,1. `RoundKey` holds across the zero cycles, and `Round` steps only on `Advance`. K1 = FFFFFFFFFFFFFFFF.
- **Full run against a model:** 80-bit random key, full run checked against a reference model. Via the encrypt stage, all-zero plaintext and key produce ciphertext 5579C1387B228445.
- **128-bit key:** `KEY_SIZE`=128, key=0. Required values:
  - K1 = 0.
  - K2 = CC00000000000000.
  - `Round` wraps to 0 at K32.
- **Restart and reset:** `Load` at `Round`=10 restarts at K1 of the new key the next cycle. `Reset` at `Round`=20 clears all outputs next cycle, and no `Done` is produced.
- **Idle and priority:** `Advance` while IDLE leaves all outputs at 0. `Load` and `Advance` in the same cycle yield K1, `Round`=1.
